// File: rtl/hnf_tracker_ctrl.sv
// Home-node tracker controller.
// Accepts requests from NUM_REQ RN-side ports, blocks any request whose 16-byte line is
// already tracked, grants at most one request per cycle round-robin, allocates the lowest
// free tracker entry, and issues the request through a one-deep lookup slot. A completion
// frees its entry and returns the original TxnID/SrcID one cycle later.
//
// Ports:
//   clock, reset                        clock and asynchronous active-high reset
//   req_valid/req_ready                 per-port request handshake (ready is one-hot)
//   req_addr/req_txnid/req_srcid        packed per-port request fields
//   lkp_valid/lkp_ready                 lookup issue handshake to the SLC/SF
//   lkp_addr/lkp_txnid/lkp_srcid/lkp_entry  fields of the issued lookup
//   comp_valid/comp_entry               completion that frees a tracker entry
//   rsp_valid/rsp_txnid/rsp_srcid       response carrying the freed entry's IDs
//   occupancy/full/err                  live entry count, full flag, sticky protocol error
module hnf_tracker_ctrl #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ENTRIES = 8,
  localparam int unsigned EW = $clog2(ENTRIES),
  localparam int unsigned RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*48-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0] req_txnid,
  input  logic [NUM_REQ*7-1:0] req_srcid,
  output logic                 lkp_valid,
  input  logic                 lkp_ready,
  output logic [47:0]          lkp_addr,
  output logic [7:0]           lkp_txnid,
  output logic [6:0]           lkp_srcid,
  output logic [EW-1:0]        lkp_entry,
  input  logic                 comp_valid,
  input  logic [EW-1:0]        comp_entry,
  output logic                 rsp_valid,
  output logic [7:0]           rsp_txnid,
  output logic [6:0]           rsp_srcid,
  output logic [EW:0]          occupancy,
  output logic                 full,
  output logic                 err
);

  logic [ENTRIES-1:0] ent_valid_q;
  logic [47:0]        ent_addr_q  [ENTRIES];
  logic [7:0]         ent_txnid_q [ENTRIES];
  logic [6:0]         ent_srcid_q [ENTRIES];
  logic [RW-1:0]      rr_q;

  logic [NUM_REQ-1:0] hazard;
  logic [NUM_REQ-1:0] eligible;
  logic               grant;
  logic [RW-1:0]      gnt_idx;
  logic [47:0]        gnt_addr;
  logic [7:0]         gnt_txnid;
  logic [6:0]         gnt_srcid;
  logic [EW-1:0]      free_idx;
  logic               comp_hit;

  assign full = (occupancy == (EW+1)'(ENTRIES));

  // A port is masked while any live entry tracks the same 16-byte line.
  always_comb begin : hazard_check
    hazard = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      for (int unsigned e = 0; e < ENTRIES; e++) begin
        if (ent_valid_q[e] && (ent_addr_q[e][47:4] == req_addr[i*48+4 +: 44])) begin
          hazard[i] = 1'b1;
        end
      end
    end
    eligible = req_valid & ~hazard;
  end

  // Round-robin pick: first eligible port at or after rr_q.
  always_comb begin : arbiter
    int unsigned cand;
    logic        found;
    cand      = 0;
    found     = 1'b0;
    gnt_idx   = '0;
    gnt_addr  = '0;
    gnt_txnid = '0;
    gnt_srcid = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(rr_q) + k) % NUM_REQ;
      if (!found && eligible[cand]) begin
        found   = 1'b1;
        gnt_idx = RW'(cand);
      end
    end
    grant = found && !full && (!lkp_valid || lkp_ready) && !reset;
    req_ready = '0;
    if (grant) begin
      req_ready[gnt_idx] = 1'b1;
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (RW'(i) == gnt_idx) begin
        gnt_addr  = req_addr[i*48 +: 48];
        gnt_txnid = req_txnid[i*8 +: 8];
        gnt_srcid = req_srcid[i*7 +: 7];
      end
    end
  end

  // Lowest-indexed free entry; only meaningful when not full.
  always_comb begin : free_pick
    free_idx = '0;
    for (int e = int'(ENTRIES) - 1; e >= 0; e--) begin
      if (!ent_valid_q[e]) begin
        free_idx = EW'(e);
      end
    end
    comp_hit = comp_valid && (32'(comp_entry) < ENTRIES) && ent_valid_q[comp_entry];
  end

  // Tracker entries. A completing entry is still valid this cycle, so it can never be the
  // one allocated on the same edge; it becomes allocatable from the next cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ent_valid_q <= '0;
      for (int unsigned e = 0; e < ENTRIES; e++) begin
        ent_addr_q[e]  <= '0;
        ent_txnid_q[e] <= '0;
        ent_srcid_q[e] <= '0;
      end
    end else begin
      if (comp_hit) begin
        ent_valid_q[comp_entry] <= 1'b0;
      end
      if (grant) begin
        ent_valid_q[free_idx] <= 1'b1;
        ent_addr_q[free_idx]  <= gnt_addr;
        ent_txnid_q[free_idx] <= gnt_txnid;
        ent_srcid_q[free_idx] <= gnt_srcid;
      end
    end
  end

  // Lookup slot, response, pointer and counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_q      <= '0;
      lkp_valid <= 1'b0;
      lkp_addr  <= '0;
      lkp_txnid <= '0;
      lkp_srcid <= '0;
      lkp_entry <= '0;
      rsp_valid <= 1'b0;
      rsp_txnid <= '0;
      rsp_srcid <= '0;
      occupancy <= '0;
      err       <= 1'b0;
    end else begin
      if (grant) begin
        rr_q      <= RW'((32'(gnt_idx) + 1) % NUM_REQ);
        lkp_valid <= 1'b1;
        lkp_addr  <= gnt_addr;
        lkp_txnid <= gnt_txnid;
        lkp_srcid <= gnt_srcid;
        lkp_entry <= free_idx;
      end else if (lkp_ready) begin
        lkp_valid <= 1'b0;
      end
      rsp_valid <= comp_hit;
      if (comp_hit) begin
        rsp_txnid <= ent_txnid_q[comp_entry];
        rsp_srcid <= ent_srcid_q[comp_entry];
      end
      occupancy <= occupancy + (EW+1)'(grant) - (EW+1)'(comp_hit);
      err       <= err | (comp_valid & ~comp_hit);
    end
  end

endmodule

// File: tb/tb_hnf_tracker_ctrl.sv
// Self-checking bench for hnf_tracker_ctrl: a vector table, directed corner sequences and
// randomized traffic, all compared against a behavioural model of the tracker.
module tb_hnf_tracker_ctrl;
  localparam int NR = 4;
  localparam int NE = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic [3:0]    req_valid;
  logic [3:0]    req_ready;
  logic [191:0]  req_addr;
  logic [31:0]   req_txnid;
  logic [27:0]   req_srcid;
  logic          lkp_valid, lkp_ready;
  logic [47:0]   lkp_addr;
  logic [7:0]    lkp_txnid;
  logic [6:0]    lkp_srcid;
  logic [2:0]    lkp_entry;
  logic          comp_valid;
  logic [2:0]    comp_entry;
  logic          rsp_valid;
  logic [7:0]    rsp_txnid;
  logic [6:0]    rsp_srcid;
  logic [3:0]    occupancy;
  logic          full, err;

  logic [47:0] a_addr [NR];
  logic [7:0]  a_txn  [NR];
  logic [6:0]  a_src  [NR];

  always_comb begin
    req_addr  = '0;
    req_txnid = '0;
    req_srcid = '0;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*48 +: 48] = a_addr[i];
      req_txnid[i*8 +: 8]  = a_txn[i];
      req_srcid[i*7 +: 7]  = a_src[i];
    end
  end

  hnf_tracker_ctrl #(.NUM_REQ(NR), .ENTRIES(NE)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_txnid(req_txnid), .req_srcid(req_srcid),
    .lkp_valid(lkp_valid), .lkp_ready(lkp_ready),
    .lkp_addr(lkp_addr), .lkp_txnid(lkp_txnid), .lkp_srcid(lkp_srcid), .lkp_entry(lkp_entry),
    .comp_valid(comp_valid), .comp_entry(comp_entry),
    .rsp_valid(rsp_valid), .rsp_txnid(rsp_txnid), .rsp_srcid(rsp_srcid),
    .occupancy(occupancy), .full(full), .err(err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid [NE];
  logic [47:0] m_addr  [NE];
  logic [7:0]  m_txn   [NE];
  logic [6:0]  m_src   [NE];
  int          m_rr;
  bit          m_lv;
  logic [47:0] m_la;
  logic [7:0]  m_lt;
  logic [6:0]  m_ls;
  int          m_le;
  bit          m_rv;
  logic [7:0]  m_rt;
  logic [6:0]  m_rs;
  bit          m_err;
  int          e_grant = -1;
  logic [3:0]  e_ready;

  function automatic int m_count();
    int c = 0;
    for (int e = 0; e < NE; e++) if (m_valid[e]) c++;
    return c;
  endfunction

  function automatic bit line_busy(logic [47:0] a);
    for (int e = 0; e < NE; e++)
      if (m_valid[e] && (m_addr[e] >> 4) == (a >> 4)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_reset();
    for (int e = 0; e < NE; e++) m_valid[e] = 1'b0;
    m_rr = 0; m_lv = 0; m_rv = 0; m_err = 0; m_le = 0;
    m_la = '0; m_lt = '0; m_ls = '0; m_rt = '0; m_rs = '0;
    e_grant = -1;
  endfunction

  function automatic void model_eval();
    e_grant = -1;
    if (m_count() < NE && (!m_lv || lkp_ready))
      for (int k = 0; k < NR; k++) begin
        int p = (m_rr + k) % NR;
        if (e_grant < 0 && req_valid[p] && !line_busy(a_addr[p])) e_grant = p;
      end
    e_ready = (e_grant >= 0) ? 4'(1 << e_grant) : 4'b0;
  endfunction

  function automatic void model_edge();
    int fr = -1;
    bit hit;
    for (int e = 0; e < NE; e++) if (fr < 0 && !m_valid[e]) fr = e;
    hit  = comp_valid && m_valid[comp_entry];
    m_rv = hit;
    if (hit) begin
      m_rt = m_txn[comp_entry];
      m_rs = m_src[comp_entry];
      m_valid[comp_entry] = 1'b0;
    end else if (comp_valid) begin
      m_err = 1'b1;
    end
    if (e_grant >= 0) begin
      m_lv = 1; m_la = a_addr[e_grant]; m_lt = a_txn[e_grant]; m_ls = a_src[e_grant];
      m_le = fr;
      m_valid[fr] = 1'b1; m_addr[fr] = a_addr[e_grant];
      m_txn[fr] = a_txn[e_grant]; m_src[fr] = a_src[e_grant];
      m_rr = (e_grant + 1) % NR;
    end else if (lkp_ready) begin
      m_lv = 0;
    end
  endfunction

  task automatic compare_outputs();
    chk("lkp_valid", 64'(lkp_valid), 64'(m_lv));
    if (m_lv) begin
      chk("lkp_addr", 64'(lkp_addr), 64'(m_la));
      chk("lkp_txnid", 64'(lkp_txnid), 64'(m_lt));
      chk("lkp_srcid", 64'(lkp_srcid), 64'(m_ls));
      chk("lkp_entry", 64'(lkp_entry), 64'(m_le));
    end
    chk("rsp_valid", 64'(rsp_valid), 64'(m_rv));
    if (m_rv) begin
      chk("rsp_txnid", 64'(rsp_txnid), 64'(m_rt));
      chk("rsp_srcid", 64'(rsp_srcid), 64'(m_rs));
    end
    chk("occupancy", 64'(occupancy), 64'(m_count()));
    chk("full", 64'(full), 64'(m_count() == NE));
    chk("err", 64'(err), 64'(m_err));
  endtask

  // Called shortly after a rising edge; returns 1 time unit after the next one.
  task automatic step();
    #3;
    model_eval();
    chk("req_ready", 64'(req_ready), 64'(e_ready));
    @(posedge clock);
    model_edge();
    #1;
    compare_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_lkp_valid", 64'(lkp_valid), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_full_err", 64'({full, err}), 64'd0);
    req_valid = '0; comp_valid = 0; lkp_ready = 0;
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic set_port(input int p, input logic [47:0] a, input logic [7:0] t,
                          input logic [6:0] s);
    a_addr[p] = a; a_txn[p] = t; a_src[p] = s;
  endtask

  typedef struct {
    logic [3:0] rv;
    logic       lr;
    logic       cv;
    logic [2:0] ce;
    logic [3:0] rdy;
    logic       lv;
    logic [2:0] le;
    logic [3:0] occ;
    logic       rsv;
    logic [7:0] rtx;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0; lkp_ready = 0; comp_valid = 0; comp_entry = '0;
    for (int p = 0; p < NR; p++) set_port(p, '0, '0, '0);
    do_reset();

    // ---- table: four ports with distinct lines, then completions and a stall ----
    vecs[0] = '{4'hf, 1'b1, 1'b0, 3'd0, 4'b0001, 1'b1, 3'd0, 4'd1, 1'b0, 8'h00};
    vecs[1] = '{4'hf, 1'b1, 1'b0, 3'd0, 4'b0010, 1'b1, 3'd1, 4'd2, 1'b0, 8'h00};
    vecs[2] = '{4'hf, 1'b1, 1'b0, 3'd0, 4'b0100, 1'b1, 3'd2, 4'd3, 1'b0, 8'h00};
    vecs[3] = '{4'hf, 1'b1, 1'b0, 3'd0, 4'b1000, 1'b1, 3'd3, 4'd4, 1'b0, 8'h00};
    vecs[4] = '{4'hf, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b0, 3'd0, 4'd4, 1'b0, 8'h00};
    vecs[5] = '{4'hf, 1'b1, 1'b1, 3'd1, 4'b0000, 1'b0, 3'd0, 4'd3, 1'b1, 8'h11};
    vecs[6] = '{4'hf, 1'b1, 1'b0, 3'd0, 4'b0010, 1'b1, 3'd1, 4'd4, 1'b0, 8'h00};
    vecs[7] = '{4'hf, 1'b0, 1'b1, 3'd2, 4'b0000, 1'b1, 3'd1, 4'd3, 1'b1, 8'h12};
    vecs[8] = '{4'hf, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b1, 3'd1, 4'd3, 1'b0, 8'h00};
    vecs[9] = '{4'hf, 1'b1, 1'b0, 3'd0, 4'b0100, 1'b1, 3'd2, 4'd4, 1'b0, 8'h00};
    for (int p = 0; p < NR; p++)
      set_port(p, 48'h1000 + 48'(p) * 48'h100, 8'h10 + 8'(p), 7'h20 + 7'(p));
    for (int v = 0; v < 10; v++) begin
      req_valid = vecs[v].rv; lkp_ready = vecs[v].lr;
      comp_valid = vecs[v].cv; comp_entry = vecs[v].ce;
      #1;
      chk($sformatf("tbl%0d_ready", v), 64'(req_ready), 64'(vecs[v].rdy));
      step();
      chk($sformatf("tbl%0d_lkp_valid", v), 64'(lkp_valid), 64'(vecs[v].lv));
      if (vecs[v].lv) chk($sformatf("tbl%0d_lkp_entry", v), 64'(lkp_entry), 64'(vecs[v].le));
      chk($sformatf("tbl%0d_occ", v), 64'(occupancy), 64'(vecs[v].occ));
      chk($sformatf("tbl%0d_rsp_valid", v), 64'(rsp_valid), 64'(vecs[v].rsv));
      if (vecs[v].rsv) chk($sformatf("tbl%0d_rsp_txnid", v), 64'(rsp_txnid), 64'(vecs[v].rtx));
    end
    comp_valid = 0;

    // ---- full tracker, completion of entry 5, pending request refills it ----
    do_reset();
    lkp_ready = 1;
    for (int k = 0; k < NE; k++) begin
      set_port(0, 48'h2000 + 48'(k) * 48'h10, 8'h40 + 8'(k), 7'h08 + 7'(k));
      req_valid = 4'b0001;
      step();
    end
    chk("fill_occ", 64'(occupancy), 64'd8);
    chk("fill_full", 64'(full), 64'd1);
    set_port(0, 48'h3000, 8'h99, 7'h33);
    #1;
    chk("full_ready", 64'(req_ready), 64'd0);
    comp_valid = 1; comp_entry = 3'd5;
    step();
    comp_valid = 0;
    chk("c5_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("c5_rsp_txnid", 64'(rsp_txnid), 64'h45);
    chk("c5_rsp_srcid", 64'(rsp_srcid), 64'h0d);
    chk("c5_full", 64'(full), 64'd0);
    #1;
    chk("c5_regrant", 64'(req_ready), 64'b0001);
    step();
    chk("c5_entry", 64'(lkp_entry), 64'd5);
    chk("c5_txnid", 64'(lkp_txnid), 64'h99);
    chk("c5_occ", 64'(occupancy), 64'd8);
    req_valid = '0;

    // ---- same-line hazard ----
    do_reset();
    lkp_ready = 1;
    set_port(1, 48'h1230, 8'h61, 7'h11);
    req_valid = 4'b0010;
    step();
    set_port(2, 48'h1238, 8'h62, 7'h12);
    req_valid = 4'b0100;
    repeat (3) begin
      #1;
      chk("haz_block", 64'(req_ready), 64'd0);
      step();
    end
    comp_valid = 1; comp_entry = 3'd0;
    #1;
    chk("haz_comp_cycle", 64'(req_ready), 64'd0);
    step();
    comp_valid = 0;
    #1;
    chk("haz_release", 64'(req_ready), 64'b0100);
    step();
    chk("haz_lkp_addr", 64'(lkp_addr), 64'h1238);
    chk("haz_lkp_entry", 64'(lkp_entry), 64'd0);
    req_valid = '0;

    // ---- lookup back-pressure then back-to-back issue ----
    do_reset();
    for (int p = 0; p < NR; p++)
      set_port(p, 48'h4000 + 48'(p) * 48'h40, 8'h70 + 8'(p), 7'h30 + 7'(p));
    req_valid = 4'hf;
    lkp_ready = 0;
    step();
    chk("bp_first_valid", 64'(lkp_valid), 64'd1);
    repeat (3) begin
      #1;
      chk("bp_ready", 64'(req_ready), 64'd0);
      step();
      chk("bp_entry", 64'(lkp_entry), 64'd0);
      chk("bp_addr", 64'(lkp_addr), 64'h4000);
    end
    lkp_ready = 1;
    for (int k = 1; k < NR; k++) begin
      #1;
      chk("b2b_ready", 64'(req_ready), 64'(1) << k);
      step();
      chk("b2b_valid", 64'(lkp_valid), 64'd1);
      chk("b2b_entry", 64'(lkp_entry), 64'(k));
    end
    req_valid = '0;
    step();
    chk("b2b_drain", 64'(lkp_valid), 64'd0);

    // ---- completion to a free entry ----
    do_reset();
    comp_valid = 1; comp_entry = 3'd3;
    step();
    comp_valid = 0;
    chk("free_comp_err", 64'(err), 64'd1);
    chk("free_comp_rsp", 64'(rsp_valid), 64'd0);
    step();
    chk("err_sticky", 64'(err), 64'd1);

    // ---- asynchronous reset with live entries ----
    do_reset();
    lkp_ready = 1;
    for (int p = 0; p < 3; p++)
      set_port(p, 48'h6000 + 48'(p) * 48'h10, 8'h50 + 8'(p), 7'h50 + 7'(p));
    req_valid = 4'b0111;
    repeat (3) step();
    chk("pre_rst_occ", 64'(occupancy), 64'd3);
    #2;
    do_reset();
    step();
    chk("post_rst_rsp", 64'(rsp_valid), 64'd0);

    // ---- randomized traffic against the model ----
    do_reset();
    e_grant = -1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc == 1000) begin
        do_reset();
        e_grant = -1;
      end
      for (int p = 0; p < NR; p++) begin
        if (!req_valid[p] || e_grant == p) begin
          req_valid[p] = ($urandom % 3) != 0;
          a_addr[p] = 48'h5A5A_0000_0000 | 48'(($urandom % 12) << 4) | 48'($urandom % 16);
          a_txn[p]  = 8'($urandom);
          a_src[p]  = 7'($urandom);
        end
      end
      lkp_ready  = ($urandom % 4) != 0;
      comp_valid = ($urandom % 3) == 0;
      comp_entry = 3'($urandom);
      if (($urandom % 10) != 0) begin
        int start = int'($urandom % NE);
        for (int k = NE - 1; k >= 0; k--)
          if (m_valid[(start + k) % NE]) comp_entry = 3'((start + k) % NE);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hnf_tracker_ctrl.md
HNF_TRACKER_CTRL -- requirements
Module: hnf_tracker_ctrl

Interface
REQ-001 Parameter NUM_REQ, default 4: number of request ports from the RN-side channels.
REQ-002 Parameter ENTRIES, default 8: number of HN tracker entries; EW = $clog2(ENTRIES).
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  NUM_REQ  per-port request valid.
REQ-006 req_ready  output  NUM_REQ  per-port accept; a transfer occurs when valid and ready are both high.
REQ-007 req_addr / req_txnid / req_srcid  input  NUM_REQ*48 / NUM_REQ*8 / NUM_REQ*7  packed per-port Addr, TxnID and SrcID.
REQ-008 lkp_valid, lkp_ready  output, input  1, 1  handshake to the SLC/SF lookup.
REQ-009 lkp_addr, lkp_txnid, lkp_srcid, lkp_entry  output  48, 8, 7, EW  fields of the issued lookup.
REQ-010 comp_valid, comp_entry  input  1, EW  completion that frees a tracker entry.
REQ-011 rsp_valid, rsp_txnid, rsp_srcid  output  1, 8, 7  original TxnID and SrcID of the freed entry.
REQ-012 occupancy, full, err  output  EW+1, 1, 1  live entry count; occupancy==ENTRIES; sticky protocol error.

Function
REQ-013 Each entry SHALL hold valid, addr[47:0], txnid[7:0] and srcid[6:0].
REQ-014 Port i is eligible when req_valid[i]=1 and no valid entry matches addr[47:4] (the 16-byte line); a line match masks the port (hazard).
REQ-015 Grant conditions: at least one eligible port, full=0, and the output slot empty or lkp_ready=1.
REQ-016 At most one grant per cycle, chosen round-robin from pointer rr; the first eligible port at or after rr wins.
REQ-017 req_ready SHALL be combinational and one-hot; only the granted port sees 1.
REQ-018 On a grant, rr SHALL become (granted+1) mod NUM_REQ; with no grant, rr holds.
REQ-019 A grant SHALL allocate the lowest-indexed free entry and load its fields on the same edge.
REQ-020 A grant SHALL load the one-deep output slot with the request fields and lkp_entry = the allocated index; lkp_valid=1 from the next cycle.
REQ-021 Latency: 1 cycle from an accepted request to lkp_valid.
REQ-022 The slot SHALL hold its contents stable while lkp_valid=1 and lkp_ready=0.
REQ-023 lkp_valid SHALL clear after the lkp_ready handshake unless a new grant reloads the slot in the same cycle (back-to-back, 1 per cycle).
REQ-024 comp_valid on a valid entry SHALL clear that entry on the edge.
REQ-025 The cycle after such a completion: rsp_valid=1, rsp_txnid/rsp_srcid = the stored values.
REQ-026 comp_valid on a free entry SHALL be ignored, set err=1, and produce no rsp_valid.
REQ-027 An entry freed in cycle N SHALL become allocatable and stop hazarding from cycle N+1, not in cycle N.
REQ-028 occupancy: +1 on alloc, -1 on valid free, unchanged when both occur in the same cycle; it never exceeds ENTRIES or drops below 0.
REQ-029 When full=1, all req_ready=0; completion processing continues.
REQ-030 Two ports presenting the same line in one cycle: only the round-robin winner is granted; the loser is hazard-masked from the next cycle.

Reset
REQ-031 While reset=1, asynchronously: all entries invalid; rr=0; lkp_valid=0; rsp_valid=0; err=0; occupancy=0; full=0; lkp_* and rsp_* data=0.
REQ-032 req_ready=0 while reset=1.
REQ-033 Reset asserted mid-transaction SHALL discard in-flight lookups and entries without generating rsp_valid.

Verification
REQ-034 Ports 0-3 valid with distinct lines, lkp_ready=1 -> grants in order 0,1,2,3 on consecutive cycles; lkp_entry 0,1,2,3; occupancy reaches 4.
REQ-035 Fill 8 entries, then present a further request -> req_ready=0 and full=1; comp_entry=5 -> rsp_valid next cycle with entry 5's txnid/srcid; the pending request is granted the following cycle into entry 5.
REQ-036 Port 1 Addr=0x1230 in flight, port 2 Addr=0x1238 -> port 2 blocked; after the port-1 completion, port 2 is granted one cycle later.
REQ-037 lkp_ready=0 for 3 cycles with lkp_valid=1 -> lkp_* fields stable and no further grants; when lkp_ready=1, back-to-back issue resumes.
REQ-038 comp_valid to a free entry -> err=1 and rsp_valid=0.
REQ-039 Apply reset with 3 entries live -> occupancy=0, lkp_valid=0 immediately (asynchronous).
